// File: rtl/memory_stage_if.sv
// Data-memory port bundle between the memory stage (master) and the dmem (slave).
interface memory_stage_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] address_dmem;
    logic [31:0]           data_dmem;
    logic                  wren_dmem;
    logic                  rden_dmem;
    logic [31:0]           q_dmem;
    logic                  dmem_ready;

    modport master (
        output address_dmem,
        output data_dmem,
        output wren_dmem,
        output rden_dmem,
        input  q_dmem,
        input  dmem_ready
    );

    modport slave (
        input  address_dmem,
        input  data_dmem,
        input  wren_dmem,
        input  rden_dmem,
        output q_dmem,
        output dmem_ready
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: X/M and M/W latches, variable-latency dmem access
// with stall generation, timeout-to-setx conversion and W->M store bypass.
module memory_stage #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           x_m_instructions_input,
    input  logic [31:0]           x_m_operand_O_input,
    input  logic [31:0]           x_m_operand_B_input,
    output logic [31:0]           x_m_instructions_output,
    output logic [31:0]           x_m_operand_O_output,
    output logic [31:0]           m_w_instructions_output,
    output logic [31:0]           data_writeback,
    output logic                  stall,
    memory_stage_if.master        dmem
);

    localparam logic [4:0]  OP_RTYPE = 5'b00000;
    localparam logic [4:0]  OP_ADDI  = 5'b00101;
    localparam logic [4:0]  OP_LW    = 5'b01000;
    localparam logic [4:0]  OP_SW    = 5'b00111;
    localparam logic [4:0]  OP_SETX  = 5'b10101;
    localparam logic [4:0]  OP_JAL   = 5'b00011;
    // Last counter value before the access is declared failed.
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    // setx instruction carrying the dmem-timeout status code 6.
    localparam logic [31:0] SETX_TIMEOUT_IR = {5'd21, 27'd6};
    localparam logic [31:0] SETX_TIMEOUT_O  = 32'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    function automatic logic [4:0] f_opcode(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[26:22];
    endfunction

    function automatic logic f_has_dest(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SETX)  || (op == OP_JAL);
    endfunction

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_xm_ir;
    logic [31:0] r_xm_o;
    logic [31:0] r_xm_b;
    logic [31:0] r_mw_ir;
    logic [31:0] r_mw_o;
    logic [31:0] r_mw_data;

    logic        w_xm_is_lw;
    logic        w_xm_is_sw;
    logic        w_in_fault;
    logic        w_rden;
    logic        w_wren;
    logic        w_pend;
    logic        w_stall;
    logic        w_mw_is_lw;
    logic [31:0] w_writeback;
    logic        w_bypass;
    logic [31:0] w_store_data;

    // Decode the X/M instruction into requests, stall, writeback and store-bypass data.
    always_comb begin
        w_xm_is_lw   = (f_opcode(r_xm_ir) == OP_LW);
        w_xm_is_sw   = (f_opcode(r_xm_ir) == OP_SW);
        w_in_fault   = (r_state == ST_FAULT);
        w_rden       = 1'b0;
        w_wren       = 1'b0;
        w_pend       = 1'b0;
        w_stall      = 1'b0;
        w_writeback  = r_mw_o;
        w_bypass     = 1'b0;
        w_store_data = r_xm_b;
        w_mw_is_lw   = (f_opcode(r_mw_ir) == OP_LW);

        if (w_in_fault) begin
            w_rden = 1'b0;
            w_wren = 1'b0;
        end else begin
            w_rden = w_xm_is_lw;
            w_wren = w_xm_is_sw;
        end
        w_pend  = w_rden | w_wren;
        w_stall = w_pend & ~dmem.dmem_ready;

        if (w_mw_is_lw) begin
            w_writeback = r_mw_data;
        end else begin
            w_writeback = r_mw_o;
        end

        w_bypass = w_xm_is_sw && (f_rd(r_xm_ir) == f_rd(r_mw_ir)) &&
                   f_has_dest(r_mw_ir) && (f_rd(r_mw_ir) != 5'd0);
        if (w_bypass) begin
            w_store_data = w_writeback;
        end else begin
            w_store_data = r_xm_b;
        end
    end

    // Access-tracking FSM: counts stall cycles and raises FAULT on timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pend && !dmem.dmem_ready) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 8'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (!w_pend || dmem.dmem_ready) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt >= CNT_LAST) begin
                        r_state <= ST_FAULT;
                        r_cnt   <= r_cnt;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Pipeline latches: X/M holds on stall; M/W takes a bubble on stall and setx on fault.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_xm_ir   <= 32'd0;
            r_xm_o    <= 32'd0;
            r_xm_b    <= 32'd0;
            r_mw_ir   <= 32'd0;
            r_mw_o    <= 32'd0;
            r_mw_data <= 32'd0;
        end else begin
            if (!w_stall) begin
                r_xm_ir <= x_m_instructions_input;
                r_xm_o  <= x_m_operand_O_input;
                r_xm_b  <= x_m_operand_B_input;
            end else begin
                r_xm_ir <= r_xm_ir;
                r_xm_o  <= r_xm_o;
                r_xm_b  <= r_xm_b;
            end

            if (w_stall) begin
                r_mw_ir   <= 32'd0;
                r_mw_o    <= 32'd0;
                r_mw_data <= 32'd0;
            end else if (w_in_fault) begin
                r_mw_ir   <= SETX_TIMEOUT_IR;
                r_mw_o    <= SETX_TIMEOUT_O;
                r_mw_data <= 32'd0;
            end else begin
                r_mw_ir   <= r_xm_ir;
                r_mw_o    <= r_xm_o;
                r_mw_data <= w_xm_is_lw ? dmem.q_dmem : 32'd0;
            end
        end
    end

    assign x_m_instructions_output = r_xm_ir;
    assign x_m_operand_O_output    = r_xm_o;
    assign m_w_instructions_output = r_mw_ir;
    assign data_writeback          = w_writeback;
    assign stall                   = w_stall;
    assign dmem.address_dmem       = r_xm_o[ADDR_WIDTH-1:0];
    assign dmem.data_dmem          = w_store_data;
    assign dmem.wren_dmem          = w_wren;
    assign dmem.rden_dmem          = w_rden;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a transaction-level
// reference model (tracks stall count per access rather than FSM states).
module tb_memory_stage;

    localparam int AW = 12;
    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] xi_ir, xi_o, xi_b;
    logic [31:0] xm_ir_out, xm_o_out, mw_ir_out, wb_out;
    logic        stall_out;

    memory_stage_if #(.ADDR_WIDTH(AW)) bus ();

    memory_stage #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clock                   (clk),
        .reset                   (rst),
        .x_m_instructions_input  (xi_ir),
        .x_m_operand_O_input     (xi_o),
        .x_m_operand_B_input     (xi_b),
        .x_m_instructions_output (xm_ir_out),
        .x_m_operand_O_output    (xm_o_out),
        .m_w_instructions_output (mw_ir_out),
        .data_writeback          (wb_out),
        .stall                   (stall_out),
        .dmem                    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_xm_ir, m_xm_o, m_xm_b;
    logic [31:0] m_mw_ir, m_mw_o, m_mw_d;
    int          m_waited;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [21:0] low);
        return {op, rd, low};
    endfunction

    function automatic logic dest_ok(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        return op == 5'b00000 || op == 5'b00101 || op == 5'b01000 ||
               op == 5'b10101 || op == 5'b00011;
    endfunction

    // One clock cycle: drive, compare against model, advance model.
    task automatic step(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                        input logic rdy, input logic [31:0] q, input logic r);
        logic        is_lw, is_sw, mem, faulting, e_rden, e_wren, e_stall;
        logic [31:0] e_wb, e_data;
        @(negedge clk);
        xi_ir = ir; xi_o = o; xi_b = b;
        bus.dmem_ready = rdy; bus.q_dmem = q; rst = r;
        #1;
        is_lw    = (m_xm_ir[31:27] == 5'b01000);
        is_sw    = (m_xm_ir[31:27] == 5'b00111);
        mem      = is_lw || is_sw;
        faulting = mem && (m_waited == TO);
        e_rden   = is_lw && !faulting;
        e_wren   = is_sw && !faulting;
        e_stall  = mem && !faulting && !rdy;
        e_wb     = (m_mw_ir[31:27] == 5'b01000) ? m_mw_d : m_mw_o;
        if (is_sw && m_xm_ir[26:22] == m_mw_ir[26:22] && dest_ok(m_mw_ir) && m_mw_ir[26:22] != 5'd0)
            e_data = e_wb;
        else
            e_data = m_xm_b;

        check_eq("xm_ir", xm_ir_out, m_xm_ir);
        check_eq("xm_o", xm_o_out, m_xm_o);
        check_eq("mw_ir", mw_ir_out, m_mw_ir);
        check_eq("writeback", wb_out, e_wb);
        check_eq("stall", 32'(stall_out), 32'(e_stall));
        check_eq("rden", 32'(bus.rden_dmem), 32'(e_rden));
        check_eq("wren", 32'(bus.wren_dmem), 32'(e_wren));
        check_eq("addr", 32'(bus.address_dmem), 32'(m_xm_o[AW-1:0]));
        check_eq("store_data", bus.data_dmem, e_data);

        if (r) begin
            m_xm_ir = 32'd0; m_xm_o = 32'd0; m_xm_b = 32'd0;
            m_mw_ir = 32'd0; m_mw_o = 32'd0; m_mw_d = 32'd0;
            m_waited = 0;
        end else if (e_stall) begin
            m_waited++;
            m_mw_ir = 32'd0; m_mw_o = 32'd0; m_mw_d = 32'd0;
        end else begin
            if (faulting) begin
                m_mw_ir = 32'hA800_0006; m_mw_o = 32'd6; m_mw_d = 32'd0;
            end else begin
                m_mw_ir = m_xm_ir; m_mw_o = m_xm_o;
                m_mw_d  = is_lw ? q : 32'd0;
            end
            m_waited = 0;
            m_xm_ir = ir; m_xm_o = o; m_xm_b = b;
        end
    endtask

    logic [4:0] ops [8];
    logic [31:0] w_lw, w_sw, w_add, w_addi5, w_sw5, w_addi0, w_sw0;

    initial begin
        ops[0] = 5'b00000; ops[1] = 5'b00101; ops[2] = 5'b01000; ops[3] = 5'b00111;
        ops[4] = 5'b00011; ops[5] = 5'b10101; ops[6] = 5'b00010; ops[7] = 5'b00110;
        w_lw    = mk(5'b01000, 5'd2, 22'd0);
        w_sw    = mk(5'b00111, 5'd7, 22'd0);
        w_add   = mk(5'b00000, 5'd3, 22'd0);
        w_addi5 = mk(5'b00101, 5'd5, 22'd0);
        w_sw5   = mk(5'b00111, 5'd5, 22'd0);
        w_addi0 = mk(5'b00101, 5'd0, 22'd0);
        w_sw0   = mk(5'b00111, 5'd0, 22'd0);

        rst = 1'b1; xi_ir = 32'd0; xi_o = 32'd0; xi_b = 32'd0;
        bus.dmem_ready = 1'b0; bus.q_dmem = 32'd0;
        repeat (2) @(posedge clk);
        m_xm_ir = 32'd0; m_xm_o = 32'd0; m_xm_b = 32'd0;
        m_mw_ir = 32'd0; m_mw_o = 32'd0; m_mw_d = 32'd0; m_waited = 0;

        // Reset state, then add passes through ignoring ready.
        step(w_add, 32'd7, 32'd0, 1'b0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t1_xm_o", xm_o_out, 32'd7);
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t1_wb", wb_out, 32'd7);

        // Single-cycle load.
        step(w_lw, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 32'd0, 1'b1, 32'hDEAD, 1'b0);
        check_eq("t2_rden", 32'(bus.rden_dmem), 32'd1);
        check_eq("t2_addr", 32'(bus.address_dmem), 32'd5);
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t2_wb", wb_out, 32'hDEAD);

        // Store held for 3 wait cycles.
        step(w_sw, 32'd9, 32'd3, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
            check_eq("t3_stall", 32'(stall_out), 32'd1);
            check_eq("t3_data", bus.data_dmem, 32'd3);
        end
        step(32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0);
        check_eq("t3_done", 32'(stall_out), 32'd0);

        // Load timeout -> setx.
        step(w_lw, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
            check_eq("t4_stall", 32'(stall_out), 32'd1);
        end
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t4_fault_nostall", 32'(stall_out), 32'd0);
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t4_setx_ir", mw_ir_out, 32'hA800_0006);
        check_eq("t4_setx_wb", wb_out, 32'd6);

        // Store bypass, and its suppression for r0.
        step(w_addi5, 32'd9, 32'd0, 1'b0, 32'd0, 1'b0);
        step(w_sw5, 32'd20, 32'd0, 1'b0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0);
        check_eq("t5_bypass", bus.data_dmem, 32'd9);
        step(w_addi0, 32'd9, 32'd0, 1'b0, 32'd0, 1'b0);
        step(w_sw0, 32'd20, 32'h55, 1'b0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0);
        check_eq("t5_r0", bus.data_dmem, 32'h55);

        // Reset during a wait.
        step(w_lw, 32'd4, 32'd0, 1'b0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        step(w_lw, 32'd8, 32'd0, 1'b0, 32'd0, 1'b1);
        step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t6_stall", 32'(stall_out), 32'd0);
        check_eq("t6_rden", 32'(bus.rden_dmem), 32'd0);
        check_eq("t6_xm_ir", xm_ir_out, 32'd0);
        check_eq("t6_mw_ir", mw_ir_out, 32'd0);

        // Randomized traffic with varying ready density.
        for (int i = 0; i < 600; i++) begin
            logic        rdy;
            logic [31:0] ir;
            int          mode;
            mode = (i / 40) % 3;
            if (mode == 0)      rdy = ($urandom_range(0, 7) != 0);
            else if (mode == 1) rdy = ($urandom_range(0, 1) != 0);
            else                rdy = ($urandom_range(0, 9) == 0);
            ir = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 22'($urandom));
            step(ir, $urandom, $urandom, rdy, $urandom, ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
